// File: rtl/rambyte_arb.sv
// Round-robin arbiter sharing one single-port byte-masked RAM between N requesters.
// Define RAMBYTE_ARB_INIT_EN to zero the whole array after every reset before traffic is accepted.

module rambyte #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            ce,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] dout_q;

    // Read returns the word as it was before this edge's byte writes land.
    always_ff @(posedge clk) begin
        if (ce) begin
            dout_q <= mem_q[addr];
            for (int b = 0; b < DW/8; b++) begin
                if (we[b]) begin
                    mem_q[addr][b*8 +: 8] <= din[b*8 +: 8];
                end
            end
        end
    end

    assign dout = dout_q;
endmodule

module rambyte_arb #(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int N  = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [N-1:0]      req_valid,
    input  logic [N*DW/8-1:0] req_we,
    input  logic [N*AW-1:0]   req_addr,
    input  logic [N*DW-1:0]   req_din,
    output logic [N-1:0]      req_ready,
    output logic [N-1:0]      rsp_valid,
    output logic [DW-1:0]     rsp_data,
    output logic              init_done
);
    localparam int BW = DW / 8;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;

    logic          found_c;
    logic [PW-1:0] grant_idx_c;
    int            best_dist_c;
    int            dist_c;
    logic [BW-1:0] sel_we_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_din_c;
    logic          run_c;
    logic          accept_c;

    logic          ram_ce;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

`ifdef RAMBYTE_ARB_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_done_q, init_done_d;

    assign run_c     = (state_q == ST_RUN);
    assign init_done = init_done_q;
`else
    assign run_c     = 1'b1;
    assign init_done = 1'b1;
`endif

    // Winner is the valid requester at the smallest circular distance from ptr.
    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = '0;
        best_dist_c = N;
        dist_c      = 0;
        for (int i = 0; i < N; i++) begin
            dist_c = (i - int'(ptr_q) + N) % N;
            if (req_valid[i] && (dist_c < best_dist_c)) begin
                best_dist_c = dist_c;
                grant_idx_c = PW'(i);
                found_c     = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we_c   = '0;
        sel_addr_c = '0;
        sel_din_c  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx_c == PW'(i)) begin
                sel_we_c   = req_we[i*BW +: BW];
                sel_addr_c = req_addr[i*AW +: AW];
                sel_din_c  = req_din[i*DW +: DW];
            end
        end
    end

    assign accept_c  = nreset && run_c && found_c;
    assign req_ready = accept_c ? (N'(1) << grant_idx_c) : '0;

    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
`ifdef RAMBYTE_ARB_INIT_EN
        if (nreset && (state_q == ST_INIT)) begin
            ram_ce   = 1'b1;
            ram_we   = '1;
            ram_addr = cnt_q;
        end else
`endif
        if (accept_c) begin
            ram_ce   = 1'b1;
            ram_we   = sel_we_c;
            ram_addr = sel_addr_c;
            ram_din  = sel_din_c;
        end
    end

    always_comb begin
        rsp_valid_d = req_ready;
        ptr_d       = ptr_q;
        if (accept_c) begin
            ptr_d = (grant_idx_c == PW'(N - 1)) ? '0 : grant_idx_c + PW'(1);
        end
`ifdef RAMBYTE_ARB_INIT_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
        init_done_d = (state_d == ST_RUN);
`endif
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
`ifdef RAMBYTE_ARB_INIT_EN
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef RAMBYTE_ARB_INIT_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
`endif
        end
    end

    rambyte #(.DW(DW), .AW(AW)) u_ram (
        .clk  (clk),
        .ce   (ram_ce),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = (|rsp_valid_q) ? ram_dout : '0;
endmodule
